// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte type, FIFO defaults and parameter helpers.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int RX_FIFO_DEPTH = 16;
    localparam int RX_FIFO_AF    = 12;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: 1W/1R register-array storage, asynchronous read, no reset.
module uart_fifo_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive byte buffer with fill level, almost-full and sticky overrun tracking.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int DEPTH     = RX_FIFO_DEPTH,
    parameter int AF_THRESH = RX_FIFO_AF,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic              flush,
    input  logic              ovr_clr,
    output logic [CW-1:0]     count,
    output logic              almost_full,
    output logic              full,
    output logic              overrun,
    output logic [7:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    if (!is_pow2(DEPTH) || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_param_err
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and AF_THRESH in 1..DEPTH");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          push, pop, drop;

    assign full        = count_q == CW'(DEPTH);
    assign almost_full = count_q >= CW'(AF_THRESH);
    assign rd_valid    = count_q != '0;
    assign count       = count_q;
    assign overrun     = overrun_q;
    assign drop_cnt    = drop_cnt_q;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign pop  = rd_valid && rd_ready && !flush;
    assign push = rx_done && !flush && (!full || pop);
    assign drop = rx_done && !flush && full && !pop;

    always_comb begin
        wr_ptr_d   = flush ? '0 : (push ? wr_ptr_q + AW'(1) : wr_ptr_q);
        rd_ptr_d   = flush ? '0 : (pop ? rd_ptr_q + AW'(1) : rd_ptr_q);
        count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
        overrun_d  = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
        drop_cnt_d = ovr_clr ? (drop ? 8'd1 : 8'd0)
                   : (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    uart_fifo_mem #(.W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (rx_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue-based reference model with per-cycle compare, directed and random traffic.
module tb_uart_rx_fifo;

    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_done = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          flush = 1'b0;
    logic          ovr_clr = 1'b0;
    logic [CW-1:0] count;
    logic          almost_full, full, overrun;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int failures = 0;

    uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .flush       (flush),
        .ovr_clr     (ovr_clr),
        .count       (count),
        .almost_full (almost_full),
        .full        (full),
        .overrun     (overrun),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO contents as a plain queue plus overrun bookkeeping.
    byte unsigned q[$];
    bit           m_ovr = 1'b0;
    int           m_drop = 0;
    bit           live = 1'b0;
    bit           m_pop, m_drop_ev;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovr  = 1'b0;
            m_drop = 0;
            live   = 1'b1;
        end else begin
            m_pop     = (q.size() > 0) && rd_ready;
            m_drop_ev = 1'b0;
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (rx_done) begin
                    if (q.size() < DEPTH) q.push_back(rx_data);
                    else m_drop_ev = 1'b1;
                end
            end
            if (ovr_clr) begin
                m_ovr  = 1'b0;
                m_drop = 0;
            end
            if (m_drop_ev) begin
                m_ovr  = 1'b1;
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("m_count", int'(count), q.size());
            chk("m_rd_valid", int'(rd_valid), int'(q.size() > 0));
            chk("m_full", int'(full), int'(q.size() == DEPTH));
            chk("m_almost_full", int'(almost_full), int'(q.size() >= AF));
            chk("m_overrun", int'(overrun), int'(m_ovr));
            chk("m_drop_cnt", int'(drop_cnt), m_drop);
            if (q.size() > 0) chk("m_rd_data", int'(rd_data), int'(q[0]));
        end
    end

    task automatic cyc(input bit rxd, input byte unsigned d, input bit rdy, input bit fl, input bit oc);
        rx_done  = rxd;
        rx_data  = d;
        rd_ready = rdy;
        flush    = fl;
        ovr_clr  = oc;
        @(posedge clk);
        #1;
        rx_done  = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        ovr_clr  = 1'b0;
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_full", int'(full), 0);

        // Basic push then pop
        cyc(1, 8'h41, 0, 0, 0);
        cyc(1, 8'h42, 0, 0, 0);
        chk("t1_count", int'(count), 2);
        chk("t1_valid", int'(rd_valid), 1);
        chk("t1_head", int'(rd_data), 8'h41);
        cyc(0, 0, 1, 0, 0);
        chk("t1_second", int'(rd_data), 8'h42);
        cyc(0, 0, 1, 0, 0);
        chk("t1_empty_count", int'(count), 0);
        chk("t1_empty_valid", int'(rd_valid), 0);

        // Overfill by one
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'(8'h10 + i), 0, 0, 0);
            if (i == 2) begin
                chk("t2_af3", int'(almost_full), 1);
                chk("t2_full3", int'(full), 0);
            end
            if (i == 3) chk("t2_full4", int'(full), 1);
        end
        chk("t2_overrun", int'(overrun), 1);
        chk("t2_drop_cnt", int'(drop_cnt), 1);
        chk("t2_count", int'(count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain", int'(rd_data), 8'h10 + i);
            cyc(0, 0, 1, 0, 0);
        end
        chk("t2_drained", int'(count), 0);

        // Push into a full FIFO while popping
        cyc(0, 0, 0, 0, 1);
        chk("t3_clr", int'(overrun), 0);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
        cyc(1, 8'h55, 1, 0, 0);
        chk("t3_count", int'(count), 4);
        chk("t3_overrun", int'(overrun), 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
        chk("t3_tail", int'(rd_data), 8'h55);
        cyc(0, 0, 1, 0, 0);

        // Streaming with wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'(8'h60 + i), 1, 0, 0);
            chk("t4_data", int'(rd_data), 8'h60 + i);
            chk("t4_count", int'(count), 1);
            cyc(0, 0, 1, 0, 0);
        end

        // Flush with coincident byte
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h70 + i), 0, 0, 0);
        cyc(1, 8'h99, 0, 1, 0);
        chk("t5_count", int'(count), 0);
        chk("t5_valid", int'(rd_valid), 0);
        chk("t5_overrun", int'(overrun), 0);
        cyc(1, 8'h3C, 0, 0, 0);
        chk("t5_next", int'(rd_data), 8'h3C);

        // Drop counter saturation, clear vs drop, reset mid-burst
        for (int i = 0; i < 3; i++) cyc(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 256; i++) cyc(1, 8'(i), 0, 0, 0);
        chk("t6_sat", int'(drop_cnt), 255);
        cyc(1, 8'hEE, 0, 0, 0);
        chk("t6_sat2", int'(drop_cnt), 255);
        cyc(1, 8'hAA, 0, 0, 1);
        chk("t6_clr_drop_ovr", int'(overrun), 1);
        chk("t6_clr_drop_cnt", int'(drop_cnt), 1);
        rst = 1'b1;
        cyc(1, 8'hBB, 1, 0, 0);
        rst = 1'b0;
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_valid", int'(rd_valid), 0);
        chk("t6_rst_ovr", int'(overrun), 0);
        chk("t6_rst_drop", int'(drop_cnt), 0);
        chk("t6_rst_af", int'(almost_full), 0);

        // Random traffic checked by the model each cycle
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < (i < 2000 ? 4 : 7),
                $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0);
        end
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
